// File: rtl/lcd_param_fifo.sv
// Single-clock parameter FIFO for the LCD path.
// Extra-bit pointers give full/empty without a separate counter. The read side is
// selectable: registered pop (1 or 2 cycle latency) or first-word-fall-through.
module lcd_param_fifo #(
  parameter int DATA_WIDTH       = 16,
  parameter int DEPTH_WIDTH      = 11,
  parameter int ALMOST_FULL_NUM  = 640,
  parameter int ALMOST_EMPTY_NUM = 4,
  parameter int FWFT             = 0,
  parameter int OUTPUT_REG       = 0
) (
  input  logic                   clk,
  input  logic                   tb_rst,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   wr_en,
  output logic                   wr_full,
  output logic                   almost_full,
  output logic [DATA_WIDTH-1:0]  rd_data,
  input  logic                   rd_en,
  output logic                   rd_empty,
  output logic                   almost_empty,
  output logic                   rd_valid,
  output logic [DEPTH_WIDTH:0]   water_level,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   err_clr
);

  localparam int DEPTH = 2 ** DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] FULL_LVL = (DEPTH_WIDTH + 1)'(DEPTH);
  localparam logic [DEPTH_WIDTH:0] AF_LVL   = (DEPTH_WIDTH + 1)'(ALMOST_FULL_NUM);
  localparam logic [DEPTH_WIDTH:0] AE_LVL   = (DEPTH_WIDTH + 1)'(ALMOST_EMPTY_NUM);

  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH_WIDTH:0]   wr_ptr;
  logic [DEPTH_WIDTH:0]   rd_ptr;
  logic [DEPTH_WIDTH-1:0] wr_addr;
  logic [DEPTH_WIDTH-1:0] rd_addr;
  logic                   wr_acc;
  logic                   rd_acc;

  // Level and flags are pure decodes of the registered pointers, so an async
  // reset of the pointers drives every flag to its idle value immediately.
  assign wr_addr      = wr_ptr[DEPTH_WIDTH-1:0];
  assign rd_addr      = rd_ptr[DEPTH_WIDTH-1:0];
  assign water_level  = wr_ptr - rd_ptr;
  assign wr_full      = (water_level == FULL_LVL);
  assign rd_empty     = (water_level == '0);
  assign almost_full  = (water_level >= AF_LVL);
  assign almost_empty = (water_level <= AE_LVL);
  assign wr_acc       = wr_en && !wr_full;
  assign rd_acc       = rd_en && !rd_empty;

  // Pointer advance on accepted operations; rejected ones leave pointers alone.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array: no reset, contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_addr] <= wr_data;
  end

  // Sticky error flags; a new error in the same cycle wins over err_clr.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && wr_full) overflow <= 1'b1;
      else if (err_clr)     overflow <= 1'b0;
      if (rd_en && rd_empty) underflow <= 1'b1;
      else if (err_clr)      underflow <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is visible as soon as it is stored; rd_en just advances.
      assign rd_data  = rd_empty ? '0 : mem[rd_addr];
      assign rd_valid = !rd_empty;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rd_data_p0;
      logic                  vld_p0;

      // ---- stage p0: capture popped word, hold it between pops ----
      always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
          rd_data_p0 <= '0;
          vld_p0     <= 1'b0;
        end else begin
          if (rd_acc) rd_data_p0 <= mem[rd_addr];
          vld_p0 <= rd_acc;
        end
      end

      if (OUTPUT_REG != 0) begin : g_oreg
        logic [DATA_WIDTH-1:0] rd_data_p1;
        logic                  vld_p1;

        // ---- stage p1: extra output register, valid follows the data ----
        always_ff @(posedge clk or posedge tb_rst) begin
          if (tb_rst) begin
            rd_data_p1 <= '0;
            vld_p1     <= 1'b0;
          end else begin
            if (vld_p0) rd_data_p1 <= rd_data_p0;
            vld_p1 <= vld_p0;
          end
        end

        assign rd_data  = rd_data_p1;
        assign rd_valid = vld_p1;
      end else begin : g_noreg
        assign rd_data  = rd_data_p0;
        assign rd_valid = vld_p0;
      end
    end
  endgenerate

endmodule

// File: tb/tb_lcd_param_fifo.sv
// Directed bench for lcd_param_fifo: default-configuration instance for the main
// flows, plus small FWFT and OUTPUT_REG instances for read-latency variants.
module tb_lcd_param_fifo;

  logic clk = 1'b0;
  logic tb_rst = 1'b1;

  // default instance
  logic [15:0] wr_data = '0;
  logic        wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
  logic        wr_full, almost_full, rd_empty, almost_empty, rd_valid, overflow, underflow;
  logic [15:0] rd_data;
  logic [11:0] water_level;

  // FWFT instance
  logic [15:0] fw_wr_data = '0;
  logic        fw_wr_en = 1'b0, fw_rd_en = 1'b0;
  logic        fw_full, fw_af, fw_empty, fw_ae, fw_valid, fw_ovf, fw_unf;
  logic [15:0] fw_rd_data;
  logic [4:0]  fw_level;

  // OUTPUT_REG instance
  logic [15:0] or_wr_data = '0;
  logic        or_wr_en = 1'b0, or_rd_en = 1'b0;
  logic        or_full, or_af, or_empty, or_ae, or_valid, or_ovf, or_unf;
  logic [15:0] or_rd_data;
  logic [4:0]  or_level;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lcd_param_fifo u_dut (
    .clk(clk), .tb_rst(tb_rst), .wr_data(wr_data), .wr_en(wr_en),
    .wr_full(wr_full), .almost_full(almost_full), .rd_data(rd_data), .rd_en(rd_en),
    .rd_empty(rd_empty), .almost_empty(almost_empty), .rd_valid(rd_valid),
    .water_level(water_level), .overflow(overflow), .underflow(underflow),
    .err_clr(err_clr)
  );

  lcd_param_fifo #(.DATA_WIDTH(16), .DEPTH_WIDTH(4), .ALMOST_FULL_NUM(12),
                   .ALMOST_EMPTY_NUM(2), .FWFT(1), .OUTPUT_REG(0)) u_fw (
    .clk(clk), .tb_rst(tb_rst), .wr_data(fw_wr_data), .wr_en(fw_wr_en),
    .wr_full(fw_full), .almost_full(fw_af), .rd_data(fw_rd_data), .rd_en(fw_rd_en),
    .rd_empty(fw_empty), .almost_empty(fw_ae), .rd_valid(fw_valid),
    .water_level(fw_level), .overflow(fw_ovf), .underflow(fw_unf), .err_clr(1'b0)
  );

  lcd_param_fifo #(.DATA_WIDTH(16), .DEPTH_WIDTH(4), .ALMOST_FULL_NUM(12),
                   .ALMOST_EMPTY_NUM(2), .FWFT(0), .OUTPUT_REG(1)) u_or (
    .clk(clk), .tb_rst(tb_rst), .wr_data(or_wr_data), .wr_en(or_wr_en),
    .wr_full(or_full), .almost_full(or_af), .rd_data(or_rd_data), .rd_en(or_rd_en),
    .rd_empty(or_empty), .almost_empty(or_ae), .rd_valid(or_valid),
    .water_level(or_level), .overflow(or_ovf), .underflow(or_unf), .err_clr(1'b0)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_errs;
    err_clr = 1'b1;
    tick;
    err_clr = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_lvl"}, water_level, 0);
    chk({tag, "_empty"}, rd_empty, 1);
    chk({tag, "_ae"}, almost_empty, 1);
    chk({tag, "_full"}, wr_full, 0);
    chk({tag, "_af"}, almost_full, 0);
    chk({tag, "_valid"}, rd_valid, 0);
    chk({tag, "_data"}, rd_data, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_unf"}, underflow, 0);
  endtask

  // watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] q[$];
    logic [15:0] exp_d;
    int wn;
    int lvl;
    logic wacc, racc;

    // ---------------- reset ----------------
    tick; tick;
    check_reset_values("rst");
    tb_rst = 1'b0;
    tick;

    // ---------------- fill to full ----------------
    for (int i = 0; i < 2048; i++) begin
      wr_en = 1'b1;
      wr_data = 16'hFFFF - 16'(i);
      tick;
      chk("fill_lvl", water_level, i + 1);
      chk("fill_af", almost_full, (i + 1) >= 640);
      chk("fill_ae", almost_empty, (i + 1) <= 4);
      chk("fill_full", wr_full, (i + 1) == 2048);
    end
    wr_data = 16'hAAAA;
    tick;
    wr_en = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("ovf_lvl", water_level, 2048);
    chk("ovf_unf", underflow, 0);

    // ---------------- drain ----------------
    for (int i = 0; i < 2048; i++) begin
      rd_en = 1'b1;
      tick;
      chk("drain_data", rd_data, 16'hFFFF - 16'(i));
      chk("drain_valid", rd_valid, 1);
      chk("drain_lvl", water_level, 2047 - i);
      chk("drain_ae", almost_empty, (2047 - i) <= 4);
      chk("drain_empty", rd_empty, i == 2047);
    end
    rd_en = 1'b0;
    tick;
    chk("idle_valid", rd_valid, 0);
    chk("idle_hold", rd_data, 16'hF800);
    rd_en = 1'b1;
    tick;
    chk("unf_set", underflow, 1);
    chk("unf_valid", rd_valid, 0);
    chk("unf_ovf_sticky", overflow, 1);
    // underflow re-triggered together with err_clr: set wins, overflow clears
    err_clr = 1'b1;
    tick;
    chk("prio_unf", underflow, 1);
    chk("prio_ovf", overflow, 0);
    rd_en = 1'b0;
    tick;
    err_clr = 1'b0;
    chk("clr_unf", underflow, 0);

    // ---------------- full with simultaneous read/write ----------------
    for (int i = 0; i < 2048; i++) begin
      wr_en = 1'b1;
      wr_data = 16'(i);
      tick;
    end
    chk("full2_full", wr_full, 1);
    rd_en = 1'b1;
    wr_data = 16'hCCCC;
    tick;
    wr_en = 1'b0;
    chk("full_both_lvl", water_level, 2047);
    chk("full_both_ovf", overflow, 1);
    chk("full_both_valid", rd_valid, 1);
    chk("full_both_data", rd_data, 0);
    for (int i = 0; i < 2047; i++) begin
      tick;
      chk("full_both_drain", rd_data, 16'(i + 1));
    end
    chk("full_both_empty", rd_empty, 1);
    rd_en = 1'b0;
    clear_errs;

    // ---------------- empty with simultaneous read/write ----------------
    wr_en = 1'b1;
    rd_en = 1'b1;
    wr_data = 16'h5A5A;
    tick;
    wr_en = 1'b0;
    chk("empty_both_lvl", water_level, 1);
    chk("empty_both_unf", underflow, 1);
    chk("empty_both_valid", rd_valid, 0);
    tick;
    rd_en = 1'b0;
    chk("empty_both_data", rd_data, 16'h5A5A);
    chk("empty_both_rvalid", rd_valid, 1);
    chk("empty_both_empty", rd_empty, 1);
    clear_errs;
    chk("errclr_unf", underflow, 0);

    // ---------------- streaming with pointer wrap ----------------
    wn = 0;
    for (int c = 0; c < 12000 && (wn < 3000 || q.size() > 0); c++) begin
      wr_en = (wn < 3000);
      wr_data = 16'h3000 ^ 16'(wn * 7);
      rd_en = (c % 4 != 3) || (wn >= 3000);
      lvl = q.size();
      wacc = wr_en && (lvl < 2048);
      racc = rd_en && (lvl > 0);
      exp_d = racc ? q[0] : 16'h0;
      tick;
      if (racc) void'(q.pop_front());
      if (wacc) begin
        q.push_back(wr_data);
        wn++;
      end
      chk("stream_lvl", water_level, q.size());
      chk("stream_valid", rd_valid, racc);
      if (racc) chk("stream_data", rd_data, exp_d);
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("stream_words", wn, 3000);
    chk("stream_end_empty", rd_empty, 1);
    clear_errs;

    // ---------------- asynchronous reset mid-operation ----------------
    rd_en = 1'b1;
    tick;
    rd_en = 1'b0;
    chk("pre_rst_unf", underflow, 1);
    for (int i = 0; i < 101; i++) begin
      wr_en = 1'b1;
      wr_data = 16'h0100 + 16'(i);
      tick;
    end
    wr_en = 1'b0;
    rd_en = 1'b1;
    tick;
    rd_en = 1'b0;
    chk("pre_rst_lvl", water_level, 100);
    chk("pre_rst_data", rd_data, 16'h0100);
    #3;
    tb_rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    tick;
    #2;
    tb_rst = 1'b0;
    wr_en = 1'b1;
    wr_data = 16'hBEEF;
    tick;
    wr_en = 1'b0;
    chk("post_rst_lvl", water_level, 1);
    rd_en = 1'b1;
    tick;
    rd_en = 1'b0;
    chk("post_rst_data", rd_data, 16'hBEEF);
    chk("post_rst_valid", rd_valid, 1);

    // ---------------- FWFT instance ----------------
    chk("fw_rst_valid", fw_valid, 0);
    fw_wr_en = 1'b1;
    fw_wr_data = 16'h1234;
    tick;
    chk("fw_first_data", fw_rd_data, 16'h1234);
    chk("fw_first_valid", fw_valid, 1);
    fw_wr_data = 16'h5678;
    tick;
    fw_wr_en = 1'b0;
    chk("fw_head_hold", fw_rd_data, 16'h1234);
    chk("fw_lvl2", fw_level, 2);
    fw_rd_en = 1'b1;
    tick;
    chk("fw_next_data", fw_rd_data, 16'h5678);
    chk("fw_lvl1", fw_level, 1);
    tick;
    fw_rd_en = 1'b0;
    chk("fw_empty_valid", fw_valid, 0);
    chk("fw_empty", fw_empty, 1);

    // ---------------- OUTPUT_REG instance ----------------
    or_wr_en = 1'b1;
    or_wr_data = 16'h1234;
    tick;
    or_wr_en = 1'b0;
    or_rd_en = 1'b1;
    tick;
    or_rd_en = 1'b0;
    chk("or_lat1_valid", or_valid, 0);
    chk("or_lat1_data", or_rd_data, 0);
    tick;
    chk("or_lat2_valid", or_valid, 1);
    chk("or_lat2_data", or_rd_data, 16'h1234);
    tick;
    chk("or_after_valid", or_valid, 0);
    chk("or_after_hold", or_rd_data, 16'h1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_param_fifo.md
LCD_PARAM_FIFO -- requirements
Module: lcd_param_fifo

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 16, width of wr_data/rd_data (legal 1..1152).
REQ-002 SHALL provide parameter DEPTH_WIDTH, default 11, giving storage depth 2**DEPTH_WIDTH entries (legal 4..16).
REQ-003 SHALL provide parameter ALMOST_FULL_NUM, default 640, almost_full threshold (legal 1..2**DEPTH_WIDTH).
REQ-004 SHALL provide parameter ALMOST_EMPTY_NUM, default 4, almost_empty threshold (legal 0..2**DEPTH_WIDTH-1).
REQ-005 SHALL provide parameter FWFT, default 0; 1 = first-word-fall-through read mode.
REQ-006 SHALL provide parameter OUTPUT_REG, default 0; 1 = extra rd_data register stage (ignored when FWFT=1).
REQ-007 clk  input  1  single clock for all logic, rising edge.
REQ-008 tb_rst  input  1  reset, asynchronous, active-high.
REQ-009 wr_data  input  DATA_WIDTH  write data.
REQ-010 wr_en  input  1  write request.
REQ-011 wr_full  output  1  level == 2**DEPTH_WIDTH.
REQ-012 almost_full  output  1  level >= ALMOST_FULL_NUM.
REQ-013 rd_data  output  DATA_WIDTH  read data.
REQ-014 rd_en  input  1  read request (pop).
REQ-015 rd_empty  output  1  level == 0.
REQ-016 almost_empty  output  1  level <= ALMOST_EMPTY_NUM.
REQ-017 rd_valid  output  1  rd_data holds a freshly popped word (non-FWFT modes).
REQ-018 water_level  output  DEPTH_WIDTH+1  current stored-entry count.
REQ-019 overflow  output  1  sticky: write attempted while full.
REQ-020 underflow  output  1  sticky: read attempted while empty.
REQ-021 err_clr  input  1  synchronous clear of overflow/underflow.

Function
REQ-022 Write pointer, read pointer SHALL be DEPTH_WIDTH+1 bits; address = low DEPTH_WIDTH bits; wrap from 2**DEPTH_WIDTH-1 to 0 without gaps.
REQ-023 Write SHALL be accepted iff wr_en && !wr_full; accepted word stored at write address, write pointer +1.
REQ-024 Read SHALL be accepted iff rd_en && !rd_empty; read pointer +1.
REQ-025 Flags and water_level SHALL derive from registered pointers; they reflect an accepted operation at the next clk edge.
REQ-026 Simultaneous accepted read and write SHALL leave water_level unchanged.
REQ-027 When full, rd_en && wr_en: read accepted, write rejected, overflow set, level becomes 2**DEPTH_WIDTH-1.
REQ-028 When empty, rd_en && wr_en: write accepted, read rejected, underflow set, level becomes 1.
REQ-029 Rejected operations SHALL not change pointers or memory.
REQ-030 FWFT=0, OUTPUT_REG=0: rd_data SHALL present popped word 1 cycle after accepted read, rd_valid high that cycle; rd_data holds otherwise.
REQ-031 FWFT=0, OUTPUT_REG=1: latency SHALL be 2 cycles; rd_valid pipelined to match.
REQ-032 FWFT=1: rd_data SHALL present the head word whenever !rd_empty, with no rd_en; rd_en advances to next word; rd_valid = !rd_empty.
REQ-033 overflow/underflow SHALL set on the triggering edge and stay set until err_clr; set has priority over err_clr in the same cycle.

Reset
REQ-034 On tb_rst: pointers 0, water_level 0, rd_empty 1, almost_empty 1, wr_full 0, almost_full 0, rd_valid 0, rd_data 0, overflow 0, underflow 0; memory contents not cleared.
REQ-035 Reset asserted mid-operation SHALL take effect immediately, discarding stored data; first write after release lands at address 0.

Verification
REQ-036 Defaults; write 2048 words 0xFFFF downward -> wr_full=1 after 2048th, water_level=2048, almost_full from level 640; extra write -> overflow=1, data unchanged.
REQ-037 Then read 2048 -> rd_data 0xFFFF..0xF800 in order, 1-cycle latency, rd_valid each; almost_empty at level 4; rd_empty after last; extra read -> underflow=1.
REQ-038 Full plus simultaneous rd_en/wr_en -> level 2047, overflow=1; empty plus both -> level 1, underflow=1, next read returns the written word.
REQ-039 Write 3000, read interleaved continuously (pointer wrap) -> no data loss, order preserved, water_level never exceeds 2048.
REQ-040 FWFT=1: write 0x1234 to empty FIFO -> rd_data=0x1234 one cycle later without rd_en; OUTPUT_REG=1 -> latency 2 cycles.
REQ-041 Assert tb_rst with level 100 -> all outputs at REQ-034 values same cycle; err_clr clears sticky flags next edge.
